// File: rtl/synchronous_ram_if.sv
// Bus bundle for the single-port synchronous RAM: command/data from the master,
// registered read data back from the memory.
interface synchronous_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output we,
    output addr,
    output din,
    input  dout
  );

  modport slave (
    input  we,
    input  addr,
    input  din,
    output dout
  );
endinterface

// File: rtl/synchronous_ram.sv
// Single-port register-array RAM with write-first registered read and an
// asynchronous active-low clear of both the array and the output register.
module synchronous_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  synchronous_ram_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] dout_r;
  logic [DEPTH-1:0]      wen_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic [DATA_WIDTH-1:0] dout_nxt_s;

  // One-hot per-word write enable decoded from the sampled address.
  always_comb begin
    wen_s = {DEPTH{1'b0}};
    if (bus.we == 1'b1) begin
      wen_s[bus.addr] = 1'b1;
    end else begin
      wen_s = {DEPTH{1'b0}};
    end
  end

  // Next output word: the write data on a write (write-first), else the stored word.
  always_comb begin
    rd_data_s  = mem_r[bus.addr];
    dout_nxt_s = {DATA_WIDTH{1'b0}};
    if (bus.we == 1'b1) begin
      dout_nxt_s = bus.din;
    end else begin
      dout_nxt_s = rd_data_s;
    end
  end

  // Storage array; reset clears every word without needing a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen_s[i]) begin
          mem_r[i] <= bus.din;
        end
      end
    end
  end

  // Registered read port so dout never follows the inputs combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r <= {DATA_WIDTH{1'b0}};
    end else begin
      dout_r <= dout_nxt_s;
    end
  end

  assign bus.dout = dout_r;
endmodule

// File: tb/tb_synchronous_ram.sv
// Directed self-checking bench for synchronous_ram: vector table plus
// hand-written sequences for reset, latency/hold and full-sweep cases.
module tb_synchronous_ram;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  synchronous_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  synchronous_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: dout=0x%02h expected=0x%02h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one operation at the falling edge, sample dout 1 ns after the rising edge.
  task automatic op(input logic w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.we   = w;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 4'h0;
    bus.din  = 8'h00;

    vecs[0]  = '{1'b1, 4'h2, 8'hAA, 8'hAA};
    vecs[1]  = '{1'b1, 4'h4, 8'h55, 8'h55};
    vecs[2]  = '{1'b0, 4'h2, 8'h00, 8'hAA};
    vecs[3]  = '{1'b0, 4'h4, 8'h00, 8'h55};
    vecs[4]  = '{1'b0, 4'h1, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 4'hF, 8'h11, 8'h11};
    vecs[6]  = '{1'b1, 4'hF, 8'h22, 8'h22};
    vecs[7]  = '{1'b0, 4'hF, 8'h00, 8'h22};
    vecs[8]  = '{1'b1, 4'h0, 8'h3C, 8'h3C};
    vecs[9]  = '{1'b0, 4'h0, 8'h00, 8'h3C};
    vecs[10] = '{1'b0, 4'hE, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 4'h2, 8'h00, 8'hAA};

    // Reset held for two cycles, then read a spread of addresses.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", bus.dout, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b0, 4'h0, 8'h00); check("reset_rd_0", bus.dout, 8'h00);
    op(1'b0, 4'h7, 8'h00); check("reset_rd_7", bus.dout, 8'h00);
    op(1'b0, 4'hF, 8'h00); check("reset_rd_F", bus.dout, 8'h00);

    for (int i = 0; i < 12; i++) begin
      op(vecs[i].we, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d", i), bus.dout, vecs[i].exp);
    end

    // Latency: an addr change between edges stays invisible until the next edge.
    op(1'b0, 4'h2, 8'h00);
    check("lat_pre", bus.dout, 8'hAA);
    bus.addr = 4'h4;
    bus.din  = 8'h77;
    #3;
    check("lat_hold_mid", bus.dout, 8'hAA);
    @(posedge clk);
    #1;
    check("lat_next_edge", bus.dout, 8'h55);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 4'h4, 8'h00);
      check($sformatf("hold_%0d", i), bus.dout, 8'h55);
    end

    // Fill with addr^A5, then a short asynchronous reset pulse away from an edge.
    for (int a = 0; a < 16; a++) begin
      op(1'b1, a[3:0], a[7:0] ^ 8'hA5);
      check($sformatf("fillA5_%0d", a), bus.dout, a[7:0] ^ 8'hA5);
    end
    op(1'b0, 4'h3, 8'h00);
    check("pre_pulse_rd3", bus.dout, 8'hA6);
    rst_n = 1'b0;
    #2;
    check("async_clear", bus.dout, 8'h00);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      op(1'b0, a[3:0], 8'h00);
      check($sformatf("post_pulse_%0d", a), bus.dout, 8'h00);
    end

    // Reset asserted right at a write edge: the write must not survive.
    @(negedge clk);
    bus.we   = 1'b1;
    bus.addr = 4'h9;
    bus.din  = 8'h99;
    @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("edge_rst_dout", bus.dout, 8'h00);
    @(negedge clk);
    bus.we = 1'b0;
    rst_n  = 1'b1;
    op(1'b0, 4'h9, 8'h00);
    check("edge_rst_rd9", bus.dout, 8'h00);

    // Full sweep with addr^5A, then read back in order.
    for (int a = 0; a < 16; a++) begin
      op(1'b1, a[3:0], a[7:0] ^ 8'h5A);
      check($sformatf("sweep_wr_%0d", a), bus.dout, a[7:0] ^ 8'h5A);
    end
    for (int a = 0; a < 16; a++) begin
      op(1'b0, a[3:0], 8'h00);
      check($sformatf("sweep_rd_%0d", a), bus.dout, a[7:0] ^ 8'h5A);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/synchronous_ram.md
Name: synchronous_ram

Overview:
- Single-port synchronous RAM, 2^ADDR_WIDTH words of DATA_WIDTH bits.
- One clock; writes and registered reads occur on the rising edge.
- Asynchronous active-low reset clears the whole array and the output register.
- Used as a small scratch or register-file memory inside a single clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word and of din/dout
ADDR_WIDTH, 4, address width; depth = 2^ADDR_WIDTH (16 words by default)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
we  input  1  write enable; 1 = write cycle, 0 = read cycle
addr  input  ADDR_WIDTH  word address for both read and write
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  registered read data

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - On rst_n falling, or whenever rst_n=0, dout and every memory word become 0 immediately, with no clock required.
  - While rst_n=0, the clock is ignored and writes are blocked.
  - Reset deassertion is synchronised externally; the first active edge is the first rising clk with rst_n=1.
- Write (we=1 at a rising clk):
  - mem[addr] <= din.
  - dout <= din (write-through / write-first): dout shows the data just written one edge later.
- Read (we=0 at a rising clk):
  - dout <= mem[addr]; latency is 1 clock from the sampled addr.
  - Memory is unchanged.
- Between edges, dout holds its value; changes to addr, din or we are not visible until the next rising edge.
- Address space:
  - Every addr value is valid; there is no out-of-range case.
  - No wrap-around logic is needed because the address is exactly ADDR_WIDTH bits.
- Words never written since the last reset read as 0.
- Back-to-back operations:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data at N+1.
  - Consecutive writes to the same address: the last one wins.
- Reset mid-operation: a write whose edge coincides with rst_n=0 is discarded, and the array remains all-zero.
- X-handling:
  - we is treated as 0 or 1 only.
  - Undriven inputs are not a supported condition; the bench must drive all inputs from reset release.
- No combinational path from any input to dout.
- Synthesis: the array is a register array (reset-clearable), not an inferred block RAM. The depth is kept small by design.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles, release, then read addresses 0x0, 0x7, 0xF with we=0 -> dout=0x00 one edge after each address.
- Basic write/read:
  - Write 0xAA to 0x2, then 0x55 to 0x4 (one edge each); dout=0xAA after the first write edge and 0x55 after the second (write-through).
  - Then read 0x2 -> dout=0xAA one edge later; read 0x4 -> dout=0x55.
  - Read 0x1 (never written) -> dout=0x00.
- Overwrite and boundaries:
  - Write 0x11 then 0x22 to 0xF; read 0xF -> 0x22.
  - Write 0x3C to 0x0; read 0x0 -> 0x3C.
  - Read 0xE -> 0x00, confirming no aliasing at the edges of the address range.
- Latency/hold:
  - Change addr between rising edges with we=0 -> dout must not change until the next rising edge.
  - Hold addr constant across several edges -> dout stays stable.
- Async reset mid-run:
  - After filling all 16 words with addr^0xA5, pulse rst_n low for 3 ns away from a clock edge -> dout=0x00 immediately.
  - Subsequent reads of all 16 addresses -> 0x00.
  - Assert rst_n=0 exactly at a write edge with din=0x99 -> the location still reads 0x00 after release.
- Full sweep: write addr^0x5A to all 16 addresses, then read all 16 in order -> each dout equals addr^0x5A, delivered one cycle after its address is sampled.
